// File: rtl/morse_decoder_if.sv
// Stimulus/result bundle between a Morse line driver and morse_decoder.
interface morse_decoder_if;
    logic       tick;
    logic       line_in;
    logic       clr;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic       busy;

    modport master (
        output tick, line_in, clr,
        input  letter, letter_valid, letter_err, busy
    );

    modport slave (
        input  tick, line_in, clr,
        output letter, letter_valid, letter_err, busy
    );
endinterface

// File: rtl/morse_decoder.sv
// Morse decoder: tick-sampled run-length measurement, dot/dash classification, S..Z lookup.
// Optional MORSE_DEC_TOLERANT_EN widens dash (2..4 units) and accepts 2-unit intra-symbol gaps.
module morse_decoder #(
    parameter int unsigned RUN_W    = 3,
    parameter int unsigned MAX_SYMS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    morse_decoder_if.slave  bus
);
    localparam int unsigned RUN_MAX = (1 << RUN_W) - 1;
    localparam int unsigned CNT_W   = $clog2(MAX_SYMS + 1);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    state_t              state;
    logic [RUN_W-1:0]    run;
    logic [MAX_SYMS-1:0] sym_bits;
    logic [CNT_W-1:0]    sym_cnt;
    logic                err_pend;
    logic [2:0]          letter_q;
    logic                valid_q;
    logic                err_q;
    logic                busy_q;

    logic                is_dot;
    logic                is_dash;
    logic                gap_err;
    logic                sym_full;
    logic [3:0]          code4;
    logic                lk_hit;
    logic [2:0]          lk_idx;

    // Mark/space timing classification on the current run length
    always_comb begin
        is_dot  = (run == RUN_W'(1));
`ifdef MORSE_DEC_TOLERANT_EN
        is_dash = (run >= RUN_W'(2)) && (run <= RUN_W'(4));
        gap_err = 1'b0;
`else
        is_dash = (run == RUN_W'(3));
        gap_err = (run == RUN_W'(2));
`endif
        sym_full = (sym_cnt == CNT_W'(MAX_SYMS));
    end

    // Letter lookup; first symbol sits in the most significant used bit
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = 3'd0;
        code4  = 4'(sym_bits);
        case (sym_cnt)
            CNT_W'(1): if (code4[0]) begin lk_hit = 1'b1; lk_idx = 3'd1; end
            CNT_W'(3): begin
                case (code4[2:0])
                    3'b000:  begin lk_hit = 1'b1; lk_idx = 3'd0; end
                    3'b001:  begin lk_hit = 1'b1; lk_idx = 3'd2; end
                    3'b011:  begin lk_hit = 1'b1; lk_idx = 3'd4; end
                    default: lk_hit = 1'b0;
                endcase
            end
            CNT_W'(4): begin
                case (code4)
                    4'b0001: begin lk_hit = 1'b1; lk_idx = 3'd3; end
                    4'b1001: begin lk_hit = 1'b1; lk_idx = 3'd5; end
                    4'b1011: begin lk_hit = 1'b1; lk_idx = 3'd6; end
                    4'b1100: begin lk_hit = 1'b1; lk_idx = 3'd7; end
                    default: lk_hit = 1'b0;
                endcase
            end
            default: lk_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            run      <= '0;
            sym_bits <= '0;
            sym_cnt  <= '0;
            err_pend <= 1'b0;
            letter_q <= 3'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.clr) begin
                state    <= IDLE;
                run      <= '0;
                sym_bits <= '0;
                sym_cnt  <= '0;
                err_pend <= 1'b0;
                busy_q   <= 1'b0;
            end else if (bus.tick) begin
                case (state)
                    IDLE: begin
                        if (bus.line_in) begin
                            state  <= MARK;
                            run    <= RUN_W'(1);
                            busy_q <= 1'b1;
                        end
                    end
                    MARK: begin
                        if (bus.line_in) begin
                            if (run != RUN_W'(RUN_MAX)) run <= run + RUN_W'(1);
                        end else begin
                            if (!(is_dot || is_dash) || sym_full) err_pend <= 1'b1;
                            if (!sym_full) begin
                                sym_bits <= MAX_SYMS'({sym_bits, is_dash});
                                sym_cnt  <= sym_cnt + CNT_W'(1);
                            end
                            state <= SPACE;
                            run   <= RUN_W'(1);
                        end
                    end
                    SPACE: begin
                        if (bus.line_in) begin
                            if (gap_err) err_pend <= 1'b1;
                            state <= MARK;
                            run   <= RUN_W'(1);
                        end else if (run == RUN_W'(2)) begin
                            // Third space unit: letter boundary
                            if (err_pend || !lk_hit) begin
                                err_q <= 1'b1;
                            end else begin
                                letter_q <= lk_idx;
                                valid_q  <= 1'b1;
                            end
                            state    <= IDLE;
                            run      <= '0;
                            sym_bits <= '0;
                            sym_cnt  <= '0;
                            err_pend <= 1'b0;
                            busy_q   <= 1'b0;
                        end else begin
                            run <= run + RUN_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.letter       = letter_q;
    assign bus.letter_valid = valid_q;
    assign bus.letter_err   = err_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_morse_decoder.sv
// Randomized self-checking bench for morse_decoder against a symbol-string reference model.
module tb_morse_decoder;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    morse_decoder_if bus ();

    morse_decoder #(.RUN_W(3), .MAX_SYMS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    exp_letter = 0;
    string pat [8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    int    mk  [8];
    int    gp  [8];
    int    nsym;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tick-sampled line unit, then a few idle cycles with no tick
    task automatic step(input bit b, input bit c, input int ev, input int ee, input int eb,
                        input string tag);
        int n;
        @(posedge clk); #1;
        bus.tick = 1'b1; bus.line_in = b; bus.clr = c;
        @(posedge clk); #1;
        bus.tick = 1'b0; bus.clr = 1'b0;
        check({tag, "/valid"},  int'(bus.letter_valid), ev);
        check({tag, "/err"},    int'(bus.letter_err),   ee);
        check({tag, "/busy"},   int'(bus.busy),         eb);
        check({tag, "/letter"}, int'(bus.letter),       exp_letter);
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(posedge clk); #1;
            check({tag, "/idle_pulse"}, int'(bus.letter_valid | bus.letter_err), 0);
        end
    endtask

    // Reference: mark/gap lengths -> symbol string -> table lookup
    function automatic void classify(output bit ok, output int idx);
        string s;
        bit    bad;
        s   = "";
        bad = (nsym > 4);
        for (int i = 0; i < nsym; i++) begin
`ifdef MORSE_DEC_TOLERANT_EN
            if (mk[i] == 1) s = {s, "."};
            else if (mk[i] >= 2 && mk[i] <= 4) s = {s, "-"};
            else bad = 1'b1;
`else
            if (mk[i] == 1) s = {s, "."};
            else if (mk[i] == 3) s = {s, "-"};
            else bad = 1'b1;
`endif
        end
`ifndef MORSE_DEC_TOLERANT_EN
        for (int i = 0; i < nsym - 1; i++) if (gp[i] == 2) bad = 1'b1;
`endif
        idx = -1;
        for (int k = 0; k < 8; k++) if (pat[k] == s) idx = k;
        ok = !bad && (idx >= 0);
    endfunction

    function automatic int dash_len();
`ifdef MORSE_DEC_TOLERANT_EN
        return int'($urandom_range(2, 4));
`else
        return 3;
`endif
    endfunction

    function automatic void load_letter(input int idx);
        string p;
        p    = pat[idx];
        nsym = p.len();
        for (int i = 0; i < nsym; i++) begin
            mk[i] = (p.getc(i) == "-") ? dash_len() : 1;
            gp[i] = 1;
        end
    endfunction

    function automatic void load_str(input string p);
        nsym = p.len();
        for (int i = 0; i < nsym; i++) begin
            mk[i] = (p.getc(i) == "-") ? 3 : 1;
            gp[i] = 1;
        end
    endfunction

    task automatic send_letter(input string tag, input int lead);
        bit ok;
        int idx;
        bit bits [$];
        classify(ok, idx);
        for (int i = 0; i < lead; i++) step(1'b0, 1'b0, 0, 0, 0, {tag, "/lead"});
        for (int i = 0; i < nsym; i++) begin
            for (int j = 0; j < mk[i]; j++) bits.push_back(1'b1);
            if (i < nsym - 1) for (int j = 0; j < gp[i]; j++) bits.push_back(1'b0);
        end
        repeat (3) bits.push_back(1'b0);
        for (int j = 0; j < bits.size(); j++) begin
            if (j == bits.size() - 1) begin
                if (ok) exp_letter = idx;
                step(bits[j], 1'b0, int'(ok), int'(!ok), 0, {tag, "/end"});
            end else begin
                step(bits[j], 1'b0, 0, 0, 1, tag);
            end
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.line_in = 1'b0; bus.clr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst/letter", int'(bus.letter), 0);
        check("rst/valid",  int'(bus.letter_valid), 0);
        check("rst/err",    int'(bus.letter_err), 0);
        check("rst/busy",   int'(bus.busy), 0);

        load_str("...");  send_letter("S", 0);
        load_str("--.."); send_letter("Z", 0);
        load_str("-.--"); send_letter("Y", 1);
        nsym = 1; mk[0] = 2; gp[0] = 1; send_letter("mark2", 0);
        load_str("....");  send_letter("H_err", 0);
        load_str(".-.-."); send_letter("overflow", 0);

        // Reset in the middle of a U
        load_str("-.--"); send_letter("Y_pre", 0);
        step(1'b1, 1'b0, 0, 0, 1, "U_cut");
        step(1'b0, 1'b0, 0, 0, 1, "U_cut");
        step(1'b1, 1'b0, 0, 0, 1, "U_cut");
        step(1'b0, 1'b0, 0, 0, 1, "U_cut");
        #1 reset_n = 1'b0;
        #2;
        exp_letter = 0;
        check("mid_rst/letter", int'(bus.letter), 0);
        check("mid_rst/busy",   int'(bus.busy), 0);
        check("mid_rst/valid",  int'(bus.letter_valid), 0);
        check("mid_rst/err",    int'(bus.letter_err), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        load_str("..."); send_letter("S_after_rst", 0);

        // clr on the third tick of a T
        load_str("-.--"); send_letter("Y_pre_clr", 0);
        step(1'b1, 1'b0, 0, 0, 1, "T_clr");
        step(1'b1, 1'b0, 0, 0, 1, "T_clr");
        step(1'b1, 1'b1, 0, 0, 0, "T_clr/clr");
        step(1'b0, 1'b0, 0, 0, 0, "T_clr/tail");
        step(1'b0, 1'b0, 0, 0, 0, "T_clr/tail");
        step(1'b0, 1'b0, 0, 0, 0, "T_clr/tail");

        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                load_letter(int'($urandom_range(0, 7)));
                for (int i = 0; i < nsym - 1; i++) gp[i] = ($urandom_range(0, 9) == 0) ? 2 : 1;
            end else begin
                nsym = int'($urandom_range(1, 5));
                for (int i = 0; i < nsym; i++) begin
                    if ($urandom_range(0, 4) == 0) mk[i] = int'($urandom_range(1, 5));
                    else mk[i] = ($urandom_range(0, 1) == 1) ? 3 : 1;
                    gp[i] = ($urandom_range(0, 9) == 0) ? 2 : 1;
                end
            end
            send_letter("rand", int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
